fd_loader: RTL and testbench

FD_LOADER -- requirements
Module: fd_loader

---
 rtl/fd_loader_pkg.sv | 47 ++++
 rtl/fd_addr_gen.sv | 32 +++
 rtl/fd_loader.sv | 166 ++++++++++++++++
 tb/tb_fd_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fd_loader_pkg.sv
// Shared types and tables for the FAST-detector candidate loader.
// FD_LOADER_EARLY_REJECT_EN selects the early-reject read order.
package fd_loader_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam int         THRES    = 30;
    localparam logic [4:0] REG_NONE = 5'd31;
    localparam logic [4:0] LAST_POS = 5'd16;

    // Circle offsets for register indices 1..16 (entry k holds index k+1)
    localparam logic signed [3:0] CIRC_DX [16] = '{
        4'sd0,  4'sd1,  4'sd2,  4'sd3,  4'sd3,  4'sd3,  4'sd2,  4'sd1,
        4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd3, -4'sd3, -4'sd2, -4'sd1};
    localparam logic signed [3:0] CIRC_DY [16] = '{
       -4'sd3, -4'sd3, -4'sd2, -4'sd1,  4'sd0,  4'sd1,  4'sd2,  4'sd3,
        4'sd3,  4'sd3,  4'sd2,  4'sd1,  4'sd0, -4'sd1, -4'sd2, -4'sd3};

    // Register index fetched at a given position of the read sequence
    function automatic logic [4:0] read_order(input logic [4:0] pos);
`ifdef FD_LOADER_EARLY_REJECT_EN
        case (pos)
            5'd0:    return 5'd0;
            5'd1:    return 5'd1;
            5'd2:    return 5'd9;
            5'd3:    return 5'd5;
            5'd4:    return 5'd13;
            5'd5:    return 5'd2;
            5'd6:    return 5'd3;
            5'd7:    return 5'd4;
            5'd8:    return 5'd6;
            5'd9:    return 5'd7;
            5'd10:   return 5'd8;
            5'd11:   return 5'd10;
            5'd12:   return 5'd11;
            5'd13:   return 5'd12;
            5'd14:   return 5'd14;
            5'd15:   return 5'd15;
            5'd16:   return 5'd16;
            default: return REG_NONE;
        endcase
`else
        return (pos <= LAST_POS) ? pos : REG_NONE;
`endif
    endfunction

endpackage

// File: rtl/fd_addr_gen.sv
// Combinational SRAM address of pixel `idx` around candidate (x,y).
module fd_addr_gen
    import fd_loader_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int ADDR_W = 12
) (
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [4:0]        idx,
    output logic [ADDR_W-1:0] addr
);

    logic signed [3:0] dx, dy;
    logic [3:0]        ci;
    logic [ADDR_W-1:0] col, row;

    always_comb begin
        ci = 4'(idx - 5'd1);
        dx = 4'sd0;
        dy = 4'sd0;
        if (idx != 5'd0) begin
            dx = CIRC_DX[ci];
            dy = CIRC_DY[ci];
        end
        // Signed offsets sign-extend; the border rule keeps results in range
        col  = ADDR_W'(x) + ADDR_W'(dx);
        row  = ADDR_W'(y) + ADDR_W'(dy);
        addr = row * ADDR_W'(IMG_W) + col;
    end

endmodule

// File: rtl/fd_loader.sv
// Loads the centre and 16 circle pixels of a FAST candidate from SRAM.
// Optional FD_LOADER_EARLY_REJECT_EN adds the 4-pixel early test.
module fd_loader
    import fd_loader_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    output logic              sramRe,
    output logic [ADDR_W-1:0] sramAddr,
    input  logic [7:0]        sramData,
    output logic [4:0]        regAddr,
    output logic              readen,
    output logic              busy,
    output logic              done,
    output logic              reject
);

    localparam logic [7:0] XMAX = 8'(IMG_W - 4);
    localparam logic [7:0] YMAX = 8'(IMG_H - 4);

    state_t            state;
    logic [4:0]        pos;
    logic [7:0]        cx, cy;
    logic [7:0]        ax, ay;
    logic [4:0]        nxt_pos, nxt_idx;
    logic [ADDR_W-1:0] nxt_addr;
    logic              border;
    logic              stop_early;

    assign busy    = (state == FETCH) || (state == DRAIN);
    assign border  = (x < 8'd3) || (y < 8'd3) || (x > XMAX) || (y > YMAX);
    assign ax      = (state == IDLE) ? x : cx;
    assign ay      = (state == IDLE) ? y : cy;
    assign nxt_pos = (state == IDLE) ? 5'd0 : pos + 5'd1;
    assign nxt_idx = read_order(nxt_pos);

    fd_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr_gen (
        .x    (ax),
        .y    (ay),
        .idx  (nxt_idx),
        .addr (nxt_addr)
    );

    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            cx <= x;
            cy <= y;
        end
    end

`ifdef FD_LOADER_EARLY_REJECT_EN
    logic [7:0] pc, p1, p5, p9, p13;
    logic [1:0] c1, c5, c9, c13;
    logic [2:0] nb, nd;
    logic       chk;

    // {bright, dark} in 9 bits so p+THRES cannot overflow
    function automatic logic [1:0] classify(input logic [7:0] pix, input logic [7:0] ctr);
        logic [8:0] a;
        logic [8:0] b;
        a = {1'b0, pix};
        b = {1'b0, ctr};
        return {a > b + 9'(THRES), a + 9'(THRES) < b};
    endfunction

    always_ff @(posedge clock) begin
        if (busy) begin
            case (regAddr)
                5'd0:    pc  <= sramData;
                5'd1:    p1  <= sramData;
                5'd5:    p5  <= sramData;
                5'd9:    p9  <= sramData;
                5'd13:   p13 <= sramData;
                default: ;
            endcase
        end
    end

    // One-cycle flag: all four test pixels are captured
    always_ff @(posedge clock or posedge reset) begin
        if (reset) chk <= 1'b0;
        else       chk <= (state == FETCH) && (regAddr == 5'd13);
    end

    assign c1  = classify(p1,  pc);
    assign c5  = classify(p5,  pc);
    assign c9  = classify(p9,  pc);
    assign c13 = classify(p13, pc);
    assign nb  = 3'(c1[1]) + 3'(c5[1]) + 3'(c9[1]) + 3'(c13[1]);
    assign nd  = 3'(c1[0]) + 3'(c5[0]) + 3'(c9[0]) + 3'(c13[0]);
    assign stop_early = chk && (state == FETCH) && (nb < 3'd2) && (nd < 3'd2);
`else
    logic unused_sram_data;
    assign unused_sram_data = ^sramData;
    assign stop_early       = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= 5'd0;
            sramRe   <= 1'b0;
            sramAddr <= '0;
            regAddr  <= REG_NONE;
            readen   <= 1'b0;
            done     <= 1'b0;
            reject   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    regAddr <= REG_NONE;
                    if (start) begin
                        readen <= 1'b0;
                        if (border) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            reject <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            pos      <= 5'd0;
                            sramRe   <= 1'b1;
                            sramAddr <= nxt_addr;
                        end
                    end
                end
                FETCH: begin
                    // regAddr tags the data returning for last cycle's read
                    regAddr <= read_order(pos);
                    if (stop_early) begin
                        state   <= DONE;
                        sramRe  <= 1'b0;
                        regAddr <= REG_NONE;
                        done    <= 1'b1;
                        reject  <= 1'b1;
                    end else if (pos == LAST_POS) begin
                        state  <= DRAIN;
                        sramRe <= 1'b0;
                    end else begin
                        pos      <= nxt_pos;
                        sramAddr <= nxt_addr;
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    regAddr <= REG_NONE;
                    readen  <= 1'b1;
                    done    <= 1'b1;
                    reject  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done   <= 1'b0;
                    reject <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fd_loader.sv
// Self-checking bench for fd_loader against a per-request pixel/cycle model.
module tb_fd_loader;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int ADDR_W = 12;

    localparam int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
`ifdef FD_LOADER_EARLY_REJECT_EN
    localparam int ORD [17] = '{0, 1, 9, 5, 13, 2, 3, 4, 6, 7, 8, 10, 11, 12, 14, 15, 16};
`else
    localparam int ORD [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
`endif
    localparam int TEST_PIX [4] = '{1, 5, 9, 13};

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        x, y;
    logic              sramRe;
    logic [ADDR_W-1:0] sramAddr;
    logic [7:0]        sramData;
    logic [4:0]        regAddr;
    logic              readen, busy, done, reject;

    logic [7:0] mem [0:4095];
    int n_checks = 0;
    int n_fail   = 0;
    int seen_reads;
    int rec [5];

    always #5 clock = ~clock;

    always @(posedge clock) if (sramRe) sramData <= mem[sramAddr];

    fd_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .y        (y),
        .sramRe   (sramRe),
        .sramAddr (sramAddr),
        .sramData (sramData),
        .regAddr  (regAddr),
        .readen   (readen),
        .busy     (busy),
        .done     (done),
        .reject   (reject)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pix_addr(input int cx, input int cy, input int idx);
        if (idx == 0) return cy * IMG_W + cx;
        return (cy + DY[idx-1]) * IMG_W + cx + DX[idx-1];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sramRe"},   32'(sramRe),   0);
        chk({tag, "_sramAddr"}, 32'(sramAddr), 0);
        chk({tag, "_regAddr"},  32'(regAddr),  31);
        chk({tag, "_readen"},   32'(readen),   0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_done"},     32'(done),     0);
        chk({tag, "_reject"},   32'(reject),   0);
    endtask

    // One request at (cx,cy); hold keeps start high and scrambles x/y during the load
    task automatic run_load(input int cx, input int cy, input bit hold);
        bit border, early, full;
        int nreads, nret, ncyc, p, nb, nd, v, exp_reg;
        border = (cx < 3) || (cy < 3) || (cx > IMG_W - 4) || (cy > IMG_H - 4);
        early  = 1'b0;
`ifdef FD_LOADER_EARLY_REJECT_EN
        if (!border) begin
            p  = int'(mem[pix_addr(cx, cy, 0)]);
            nb = 0;
            nd = 0;
            foreach (TEST_PIX[i]) begin
                v = int'(mem[pix_addr(cx, cy, TEST_PIX[i])]);
                if (v > p + 30) nb++;
                if (v + 30 < p) nd++;
            end
            early = (nb < 2) && (nd < 2);
        end
`endif
        // Early test: pixel 13 is the 5th read, returns a cycle later, decided a cycle after that
        if (border)     begin nreads = 0;  nret = 0;  ncyc = 1;  end
        else if (early) begin nreads = 7;  nret = 6;  ncyc = 8;  end
        else            begin nreads = 17; nret = 17; ncyc = 19; end
        full = !border && !early;
        seen_reads = 0;

        @(negedge clock);
        x = 8'(cx);
        y = 8'(cy);
        start = 1'b1;
        for (int c = 1; c <= ncyc + 1; c++) begin
            @(negedge clock);
            if (!hold || c == ncyc + 1) start = 1'b0;
            else begin
                x = 8'($urandom);
                y = 8'($urandom);
            end
            if (sramRe === 1'b1) begin
                if (seen_reads < 5) rec[seen_reads] = int'(sramAddr);
                seen_reads++;
            end
            chk("sramRe", 32'(sramRe), 32'(c <= nreads));
            if (c <= nreads) chk("sramAddr", 32'(sramAddr), pix_addr(cx, cy, ORD[c-1]));
            exp_reg = (c >= 2 && c - 2 < nret) ? ORD[c-2] : 31;
            chk("regAddr", 32'(regAddr), exp_reg);
            if (exp_reg != 31) chk("sramData", 32'(sramData), 32'(mem[pix_addr(cx, cy, exp_reg)]));
            chk("busy", 32'(busy), 32'(c < ncyc));
            chk("done", 32'(done), 32'(c == ncyc));
            if (c == ncyc) chk("reject", 32'(reject), 32'(!full));
            chk("readen", 32'(readen), (c >= ncyc) ? 32'(full) : 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x = 8'd0;
        y = 8'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        run_load(10, 10, 1'b0);
`ifndef FD_LOADER_EARLY_REJECT_EN
        chk("seq_addr0", rec[0], 650);
        chk("seq_addr1", rec[1], 458);
        chk("seq_addr2", rec[2], 459);
        chk("seq_addr3", rec[3], 524);
        chk("seq_addr4", rec[4], 589);
        chk("full_reads", seen_reads, 17);
`endif
        run_load(2, 20, 1'b0);
        chk("border_reads", seen_reads, 0);

        run_load(20, 30, 1'b1);

        // Reset in the 8th FETCH cycle abandons the request
        @(negedge clock);
        x = 8'd10;
        y = 8'd10;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        chk("midfetch_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            chk("abandon_done", 32'(done), 0);
            chk("abandon_readen", 32'(readen), 0);
        end

        run_load(5, 63, 1'b0);
        run_load(3, 3, 1'b0);
        run_load(60, 60, 1'b0);
        run_load(61, 30, 1'b0);
        run_load(30, 61, 1'b0);
        run_load(30, 2, 1'b0);

        for (int i = 0; i < 20; i++)
            run_load(int'($urandom_range(0, 66)), int'($urandom_range(0, 66)), 1'($urandom_range(0, 1)));

`ifdef FD_LOADER_EARLY_REJECT_EN
        mem[pix_addr(10, 10, 0)] = 8'd100;
        foreach (TEST_PIX[i]) mem[pix_addr(10, 10, TEST_PIX[i])] = 8'd110;
        run_load(10, 10, 1'b0);
        chk("early_reads", seen_reads, 7);
        mem[pix_addr(10, 10, 1)] = 8'd140;
        mem[pix_addr(10, 10, 5)] = 8'd140;
        run_load(10, 10, 1'b0);
        chk("pass_reads", seen_reads, 17);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
